// File: rtl/sseg_pkg.sv
// rtl/sseg_pkg.sv - shared segment/anode constants and digit index type for sseg_scan_mux
package sseg_pkg;

  typedef logic [1:0] digit_idx_t;

  localparam logic [6:0] SEG_0    = 7'b1000000;
  localparam logic [6:0] SEG_1    = 7'b1111001;
  localparam logic [6:0] SEG_2    = 7'b0100100;
  localparam logic [6:0] SEG_3    = 7'b0110000;
  localparam logic [6:0] SEG_4    = 7'b0011001;
  localparam logic [6:0] SEG_5    = 7'b0010010;
  localparam logic [6:0] SEG_6    = 7'b0000010;
  localparam logic [6:0] SEG_7    = 7'b1111000;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0010000;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_OFF  = 7'h7F;
  localparam logic [3:0] AN_OFF   = 4'b1111;

endpackage

// File: rtl/bcd_to_sseg.sv
// rtl/bcd_to_sseg.sv - combinational BCD to active-low {g..a} decoder, codes 10..15 show a dash
module bcd_to_sseg
  import sseg_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/sseg_scan_mux.sv
// rtl/sseg_scan_mux.sv - 4-digit common-anode scan multiplexer; SSEG_LEADING_ZERO_BLANK_EN enables leading-zero suppression
module sseg_scan_mux
  import sseg_pkg::*;
#(
  parameter  int DIV   = 100000,
  localparam int CNT_W = $clog2(DIV)
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] d3,
  input  logic [3:0] d2,
  input  logic [3:0] d1,
  input  logic [3:0] d0,
  input  logic [3:0] dp_in,
  input  logic       blank,
  output logic [3:0] an,
  output logic [7:0] sseg
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  digit_idx_t       idx_q, idx_d;
  logic [3:0]       an_q, an_d;
  logic [7:0]       sseg_q, sseg_d;
  logic [3:0]       digit;
  logic [6:0]       seg;
  logic             suppress;
  logic             terminal;

  bcd_to_sseg u_dec (
    .bcd (digit),
    .seg (seg)
  );

  always_comb begin
    terminal = (cnt_q == CNT_W'(DIV - 1));
    cnt_d    = terminal ? '0 : cnt_q + 1'b1;
    idx_d    = terminal ? idx_q + 2'd1 : idx_q;
  end

  always_comb begin
    digit = d0;
    case (idx_q)
      2'd0: digit = d0;
      2'd1: digit = d1;
      2'd2: digit = d2;
      2'd3: digit = d3;
      default: digit = d0;
    endcase
  end

`ifdef SSEG_LEADING_ZERO_BLANK_EN
  // A slot is dark when it and every digit to its left are zero; digit 0 always shows.
  always_comb begin
    suppress = 1'b0;
    case (idx_q)
      2'd3: suppress = (d3 == 4'd0);
      2'd2: suppress = (d3 == 4'd0) && (d2 == 4'd0);
      2'd1: suppress = (d3 == 4'd0) && (d2 == 4'd0) && (d1 == 4'd0);
      default: suppress = 1'b0;
    endcase
  end
`else
  assign suppress = 1'b0;
`endif

  always_comb begin
    an_d   = AN_OFF;
    sseg_d = {1'b1, SEG_OFF};
    if (!blank && !suppress) begin
      an_d   = ~(4'b0001 << idx_q);
      sseg_d = {~dp_in[idx_q], seg};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      idx_q  <= '0;
      an_q   <= AN_OFF;
      sseg_q <= 8'hFF;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      an_q   <= an_d;
      sseg_q <= sseg_d;
    end
  end

  assign an   = an_q;
  assign sseg = sseg_q;

endmodule

// File: tb/tb_sseg_scan_mux.sv
// tb/tb_sseg_scan_mux.sv - self-checking bench for sseg_scan_mux with DIV=4
module tb_sseg_scan_mux;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic [3:0] d3 = 4'd0, d2 = 4'd0, d1 = 4'd0, d0 = 4'd0;
  logic [3:0] dp_in = 4'd0;
  logic       blank = 1'b0;
  logic [3:0] an;
  logic [7:0] sseg;

  int total = 0;
  int bad = 0;
  int edges = 0;

  typedef struct {
    logic [3:0] val;
    logic [6:0] seg;
  } vec_t;

  vec_t vecs [16];

  logic [6:0] seg_ref [0:9];

  sseg_scan_mux #(.DIV(DIV)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .d3      (d3),
    .d2      (d2),
    .d1      (d1),
    .d0      (d0),
    .dp_in   (dp_in),
    .blank   (blank),
    .an      (an),
    .sseg    (sseg)
  );

  always #5 clk = ~clk;

  function automatic int cur_idx(input int e);
    return ((e - 1) / DIV) % 4;
  endfunction

  function automatic bit suppressed(input int i);
    bit s;
    s = 1'b0;
`ifdef SSEG_LEADING_ZERO_BLANK_EN
    if (i == 3) s = (d3 == 0);
    if (i == 2) s = (d3 == 0) && (d2 == 0);
    if (i == 1) s = (d3 == 0) && (d2 == 0) && (d1 == 0);
`endif
    return s;
  endfunction

  // Expected {an, sseg} after edge e counted from reset release, from the current inputs.
  function automatic logic [11:0] model(input int e);
    int i;
    int v;
    logic [3:0] onehot;
    logic [6:0] s;
    if (e == 0) return 12'hFFF;
    i = cur_idx(e);
    if (blank || suppressed(i)) return 12'hFFF;
    case (i)
      0: v = d0;
      1: v = d1;
      2: v = d2;
      default: v = d3;
    endcase
    s = (v <= 9) ? seg_ref[v] : 7'b0111111;
    onehot = 4'd0;
    onehot[i] = 1'b1;
    return {~onehot, ~dp_in[i], s};
  endfunction

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got an=%b sseg=%b, want an=%b sseg=%b (edge %0d)",
               name, act[11:8], act[7:0], exp[11:8], exp[7:0], edges);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    edges++;
    #1;
  endtask

  task automatic step(input string name);
    tick();
    chk(name, {an, sseg}, model(edges));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("reset_async_dark", {an, sseg}, 12'hFFF);
    @(posedge clk);
    #1;
    chk("reset_held_dark", {an, sseg}, 12'hFFF);
    @(negedge clk);
    reset_n = 1'b1;
    edges = 0;
  endtask

  logic [3:0] an_seq  [0:3];
  logic [6:0] seg_seq [0:3];
  logic [3:0] an_exp;

  initial begin
    seg_ref = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    for (int i = 0; i < 16; i++) begin
      vecs[i].val = 4'(i);
      vecs[i].seg = 7'b0111111;
    end
    vecs[0].seg = 7'b1000000; vecs[1].seg = 7'b1111001; vecs[2].seg = 7'b0100100;
    vecs[3].seg = 7'b0110000; vecs[4].seg = 7'b0011001; vecs[5].seg = 7'b0010010;
    vecs[6].seg = 7'b0000010; vecs[7].seg = 7'b1111000; vecs[8].seg = 7'b0000000;
    vecs[9].seg = 7'b0010000;
    an_seq  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    seg_seq = '{7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001};

    // Reset and release: first edge presents digit 0.
    d3 = 4'd4; d2 = 4'd3; d1 = 4'd2; d0 = 4'd1; dp_in = 4'b0000;
    do_reset();
    tick();
    chk("first_edge_digit0", {an, sseg}, {4'b1110, 1'b1, 7'b1111001});

    // Scan order with explicit slot constants.
    for (int k = 2; k <= 17; k++) begin
      tick();
      chk("scan_order", {an, sseg}, {an_seq[((k - 1) / 4) % 4], 1'b1, seg_seq[((k - 1) / 4) % 4]});
    end

    // Table: every BCD code on all four digits.
    for (int i = 0; i < 16; i++) begin
      logic [11:0] e;
      d3 = vecs[i].val; d2 = vecs[i].val; d1 = vecs[i].val; d0 = vecs[i].val;
      tick();
      an_exp = 4'd0;
      an_exp[cur_idx(edges)] = 1'b1;
      e = suppressed(cur_idx(edges)) ? 12'hFFF : {~an_exp, 1'b1, vecs[i].seg};
      chk("decode_table", {an, sseg}, e);
    end

    // Invalid BCD on d2 with its decimal point.
    d3 = 4'd4; d2 = 4'hB; d1 = 4'd2; d0 = 4'd1; dp_in = 4'b0100;
    do_reset();
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (cur_idx(edges) == 2)
        chk("invalid_dp_slot2", {an, sseg}, {4'b1011, 8'b0_0111111});
      else
        chk("dp_off_other", {3'b000, sseg[7]}, 4'b0001);
    end
    dp_in = 4'b0000;

    // Blank for 6 cycles starting in slot 1.
    d2 = 4'd3;
    do_reset();
    for (int k = 1; k <= 5; k++) step("pre_blank");
    blank = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("blank_dark", {an, sseg}, 12'hFFF);
    end
    blank = 1'b0;
    tick();
    chk("blank_resume_slot2", {4'b0000, an}, {4'b0000, 4'b1011});
    tick();
    chk("blank_resume_slot3", {an, sseg}, {4'b0111, 1'b1, 7'b0011001});
    for (int k = 0; k < 6; k++) step("post_blank");

    // Reset pulse between edges in slot 2.
    do_reset();
    for (int k = 1; k <= 10; k++) step("pre_midreset");
    #2;
    reset_n = 1'b0;
    #1;
    chk("midreset_async", {an, sseg}, 12'hFFF);
    @(posedge clk);
    #1;
    chk("midreset_held", {an, sseg}, 12'hFFF);
    @(negedge clk);
    reset_n = 1'b1;
    edges = 0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("midreset_full_slot0", {an, sseg}, {4'b1110, 1'b1, 7'b1111001});
    end
    tick();
    chk("midreset_slot1", {4'b0000, an}, {4'b0000, 4'b1101});

`ifdef SSEG_LEADING_ZERO_BLANK_EN
    d3 = 4'd0; d2 = 4'd0; d1 = 4'd0; d0 = 4'd7;
    do_reset();
    for (int k = 1; k <= 16; k++) begin
      tick();
      chk("lz_0007", {an, sseg}, (cur_idx(edges) == 0) ? {4'b1110, 1'b1, 7'b1111000} : 12'hFFF);
    end
    d0 = 4'd0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      chk("lz_0000", {an, sseg}, (cur_idx(edges) == 0) ? {4'b1110, 1'b1, 7'b1000000} : 12'hFFF);
    end
`endif

    // Randomized stimulus against the reference model.
    do_reset();
    for (int k = 0; k < 600; k++) begin
      d3 = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      d2 = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      d1 = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      d0 = 4'($urandom_range(0, 15));
      dp_in = 4'($urandom_range(0, 15));
      blank = ($urandom_range(0, 7) == 0);
      step("random");
    end
    blank = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sseg_scan_mux.md
Name: sseg_scan_mux

Overview:
- Display stage directly downstream of the BCD event counter.
- Takes its four BCD digits (d3..d0) and time-multiplexes them onto a common-anode 4-digit seven-segment display.
- Contains a refresh divider, a digit-select scan sequencer, a BCD-to-segment decoder and registered anode/segment outputs.
- Sits at the board boundary, between the counter and the FPGA display pins.

Parameters:
- DIV, 100000, clock cycles each digit stays lit (1 ms at 100 MHz); legal range DIV >= 2.
- CNT_W, $clog2(DIV), width of the refresh divider counter (derived; never overridden).

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- d3  input  4  BCD digit, most significant (leftmost).
- d2  input  4  BCD digit.
- d1  input  4  BCD digit.
- d0  input  4  BCD digit, least significant (rightmost).
- dp_in  input  4  decimal-point request per digit, active-high; bit i belongs to digit i.
- blank  input  1  active-high; forces every digit off.
- an  output  4  anode enables, active-low; an[i] drives digit i.
- sseg  output  8  cathodes, active-low; sseg[7] = dp, sseg[6:0] = {g,f,e,d,c,b,a}.

Behaviour:
- Reset (reset_n low, asynchronous): divider = 0, idx = 0, an = 4'b1111, sseg = 8'hFF. Every output is dark while reset is held.
- Divider: counts 0..DIV-1 and wraps to 0 on the cycle after DIV-1. Its terminal count (cnt == DIV-1) advances idx 0->1->2->3->0. idx is 2 bits and wraps naturally.
- Output register:
  - Every rising edge loads an = ~(4'b0001 << idx) and sseg = {~dp_in[idx], seg(d_idx)}, using the current idx and current inputs.
  - Latency from idx change or input change to pins is 1 cycle.
  - an and sseg always update on the same edge and stay aligned.
  - The first edge after reset release presents digit 0.
- Inputs are sampled continuously, not latched per scan slot. A digit change mid-slot appears on the next edge.
- seg() encoding, active-low {g..a}:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Any value 10..15 decodes as dash 0111111 (segment g only), never as a hex glyph.
- blank = 1: next edge loads an = 4'b1111 and sseg = 8'hFF. The divider and idx keep running, so scan phase is preserved. When blank drops, the display resumes at the current idx with no restart.
- Scan sequence per full refresh: digit 0, 1, 2, 3, each lit exactly DIV cycles. Full frame = 4*DIV cycles.
- Reset asserted mid-slot: immediate dark outputs; divider and idx return to 0.

Optional Feature:
- Macro: SSEG_LEADING_ZERO_BLANK_EN.
- Defined: leading-zero suppression.
  - Digit 3 is suppressed when d3 == 0.
  - Digit 2 is suppressed when d3 == 0 and d2 == 0.
  - Digit 1 is suppressed when d3, d2 and d1 are all 0.
  - Digit 0 is never suppressed.
  - A suppressed slot drives an = 4'b1111 and sseg = 8'hFF for its full DIV cycles, including its dp.
  - Scan timing is unchanged.
- Not defined: all four digits are always displayed, including leading zeros.

Decomposition:
- Shared package sseg_pkg:
  - segment constants SEG_0..SEG_9.
  - SEG_DASH = 7'b0111111.
  - SEG_OFF = 7'h7F.
  - AN_OFF = 4'b1111.
  - typedef for the 2-bit digit index.
- One sub-module, bcd_to_sseg: purely combinational 4-bit BCD in, 7-bit active-low segments out, with invalid codes mapped to SEG_DASH.
- Divider, index sequencer, digit mux, blanking and output registers live in sseg_scan_mux.

Test Plan (DIV=4 unless stated):
- Reset and release: hold reset_n=0 -> an=1111, sseg=FF. Release -> first edge an=1110 and sseg[6:0]=SEG(d0). Divider and idx start from 0.
- Scan order: d3..d0 = 4,3,2,1, dp_in=0000.
  - an must follow 1110 (4 cycles) -> 1101 -> 1011 -> 0111 -> 1110.
  - sseg[6:0] = 1111001, 0100100, 0110000, 0011001 in matching slots.
  - sseg[7]=1 throughout.
- Invalid BCD and dp: d2=4'hB, dp_in=0100 -> during the an=1011 slot, sseg = 8'b0_0111111. All other slots have sseg[7]=1.
- Blank mid-slot: assert blank for 6 cycles starting in slot 1 -> an=1111 and sseg=FF one edge later. On release, the display resumes at the slot index implied by the uninterrupted divider.
- Reset mid-scan: pulse reset_n low in slot 2 between clock edges -> outputs go dark asynchronously. After release the scan restarts at digit 0 with a full 4-cycle slot.
- Leading-zero suppression (macro defined): d3..d0 = 0,0,0,7 -> slots 3, 2 and 1 show an=1111; slot 0 shows an=1110, sseg[6:0]=1111000. Repeat with d = 0,0,0,0 -> only digit 0 is lit, showing 1000000.
